mcu51_serial_rx: RTL and testbench
==================================

// Module: mcu51_serial_rx
// PURPOSE
//  Receives 8051 serial mode-1 frames (1 start, 8 data LSB-first, 1 stop) driven by the MCU on
//  P3[1] (TXD) and presents them as bytes through a valid/ready interface with a small FIFO.
//  It is the far end of the MCU's serial link: in simulation it sits beside top and checks TXD
//  traffic; on the board it is the host-side capture path.
// PARAMETERS
//  CLKS_PER_BIT  16  CLK cycles per serial bit; even, >= 4
//  FIFO_DEPTH    4   received-byte buffer entries; power of two, >= 2
// PORTS
//  CLK          in   1  system clock, rising edge
//  reset        in   1  synchronous, active-high reset
//  rxd          in   1  serial line (P3[1]); asynchronous to CLK, idles high
//  clr_overrun  in   1  one-cycle pulse clears overrun
//  rx_ready     in   1  consumer accepts rx_data this cycle
//  rx_data      out  8  FIFO head byte; valid only while rx_valid=1
//  rx_valid     out  1  FIFO not empty
//  frame_err    out  1  one-cycle pulse: stop bit sampled 0
//  overrun      out  1  sticky: a byte was dropped because the FIFO was full
//  busy         out  1  receiver FSM not in IDLE
// BEHAVIOUR
//  - Clock is CLK; reset is synchronous, active-high. Reset values: rx_data=0, rx_valid=0,
//    frame_err=0, overrun=0, busy=0, FSM=IDLE, FIFO empty, synchroniser flops=1.
//  - rxd passes through a 2-flop synchroniser; all decisions use the synchronised value rxs.
//  - A bit counter reloads to CLKS_PER_BIT-1 and counts down; "tick" = counter reaches 0.
//  - FSM states (stored in a 3-bit register):
//    IDLE: on rxs=0 -> START; counter = CLKS_PER_BIT/2-1.
//    START: on tick sample rxs: 1 -> IDLE (glitch, nothing reported); 0 -> DATA, bit_idx=0.
//    DATA: on each tick shift rxs into bit 7 of the shift register (LSB first); after bit_idx=7 -> STOP.
//    STOP: on tick sample rxs: 1 -> push byte, go to IDLE; 0 -> frame_err=1 for one cycle,
//      byte discarded, go to BREAK.
//    BREAK: stay until rxs=1, then IDLE (a held-low line does not retrigger).
//  - Sample points therefore fall at mid-bit. Latency: rx_valid rises the cycle after the stop
//    sample, i.e. 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after rxd falls (empty FIFO).
//  - busy=1 in START, DATA, STOP and BREAK.
//  - FIFO: show-ahead; rx_data = head entry. A pop occurs when rx_valid & rx_ready.
//    Push when full and no pop in the same cycle: byte dropped, overrun<=1. Push and pop in the
//    same cycle while full: both take effect, no overrun. Push and pop in the same cycle while empty
//    is impossible; rx_valid is registered from the count. Pointers wrap modulo FIFO_DEPTH; count
//    width is $clog2(FIFO_DEPTH+1).
//  - overrun clears on clr_overrun; if clr_overrun and a new overrun coincide, overrun stays 1.
//  - A reset mid-frame abandons the frame: there is no partial push and no frame_err.
//  - rx_ready while rx_valid=0 is ignored.
// STRUCTURE
//  - Shared package mcu51_uart_pkg: FSM state localparams (IDLE, START, DATA, STOP, BREAK),
//    UART_DATA_W=8, and the frame-length constant 10.
//  - Sub-module mcu51_rx_fifo (DEPTH, WIDTH; push/pop/full/empty/count). The FSM, counter and
//    synchroniser stay in the top module.
// TESTING (CLKS_PER_BIT=8, FIFO_DEPTH=4, 10 ns CLK)
//  1. Frame 0xA5 with a valid stop bit, rx_ready=1 -> rx_valid high for 1 cycle, rx_data=0xA5,
//     frame_err=0, rx_valid asserted 79 cycles after the rxd falling edge.
//  2. rxd low for 3 cycles then high -> busy pulses, FSM returns to IDLE, no rx_valid, no frame_err.
//  3. Frame 0x3C with stop=0, then rxd held low 40 cycles, then frame 0x55 -> one frame_err pulse,
//     0x3C never appears, busy stays 1 through the low hold, 0x55 is received.
//  4. rx_ready=0, frames 0x01..0x05 -> FIFO holds 01,02,03,04 and overrun=1; then rx_ready=1 ->
//     pops 01,02,03,04 in order and rx_valid falls; clr_overrun -> overrun=0.
//  5. FIFO full with rx_ready asserted on the same cycle as the 5th push -> 01 popped, 05 stored,
//     overrun stays 0.
//  6. reset=1 for one cycle after data bit 3 of a frame -> all outputs return to reset values; the
//     next full frame 0x80 is received correctly.

Source files
------------

// File: rtl/mcu51_uart_pkg.sv
// Shared constants and receiver FSM state encoding for the 8051 mode-1 serial link.
package mcu51_uart_pkg;

    localparam int unsigned UART_DATA_W     = 8;
    localparam int unsigned UART_FRAME_BITS = 10;
    localparam int unsigned UART_STATE_W    = 3;

    typedef enum logic [UART_STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

endpackage

// File: rtl/mcu51_rx_fifo.sv
// Show-ahead receive FIFO; the head byte is held in a register so the read port is flop-driven.
module mcu51_rx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_empty;
    logic [WIDTH-1:0] r_head;

    logic             w_pop;
    logic             w_push;
    logic [PTR_W-1:0] w_rd_next;
    logic [CNT_W-1:0] w_count_next;
    logic [WIDTH-1:0] w_head_next;

    assign w_pop        = i_pop & ~r_empty;
    assign w_push       = i_push & (~r_full | w_pop);
    assign w_rd_next    = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    // A write landing on the next head slot bypasses the memory read.
    assign w_head_next  = (w_push && (r_wr_ptr == w_rd_next)) ? i_wdata : r_mem[w_rd_next];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_head   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
            r_full   <= (w_count_next == CNT_W'(DEPTH));
            r_empty  <= (w_count_next == '0);
            r_head   <= w_head_next;
        end
    end

    assign o_rdata = r_head;
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/mcu51_serial_rx.sv
// Mode-1 serial receiver: synchroniser, mid-bit sampling FSM and byte FIFO with valid/ready output.
module mcu51_serial_rx
    import mcu51_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   rxd,
    input  logic                   clr_overrun,
    input  logic                   rx_ready,
    output logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   frame_err,
    output logic                   overrun,
    output logic                   busy
);

    localparam int unsigned     CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       LAST_BIT = 3'(UART_FRAME_BITS - 3);

    rx_state_e              r_state;
    logic                   r_sync1;
    logic                   r_rxs;
    logic [CNT_W-1:0]       r_cnt;
    logic [2:0]             r_bit_idx;
    logic [UART_DATA_W-1:0] r_shift;
    logic                   r_frame_err;
    logic                   r_overrun;
    logic                   r_busy;

    rx_state_e              w_state_next;
    logic [CNT_W-1:0]       w_cnt_next;
    logic [2:0]             w_bit_next;
    logic [UART_DATA_W-1:0] w_shift_next;
    logic                   w_tick;
    logic                   w_push;
    logic                   w_ferr_next;
    logic                   w_pop;
    logic                   w_drop;
    logic                   w_full;
    logic                   w_empty;

    assign w_tick = (r_cnt == '0);

    // Next-state, counter and datapath decode.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = w_tick ? CNT_FULL : r_cnt - CNT_W'(1);
        w_bit_next   = r_bit_idx;
        w_shift_next = r_shift;
        w_push       = 1'b0;
        w_ferr_next  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!r_rxs) begin
                    w_state_next = ST_START;
                    w_cnt_next   = CNT_HALF;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    if (r_rxs) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_DATA;
                        w_bit_next   = 3'd0;
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shift_next = {r_rxs, r_shift[UART_DATA_W-1:1]};
                    if (r_bit_idx == LAST_BIT) begin
                        w_state_next = ST_STOP;
                    end else begin
                        w_bit_next = r_bit_idx + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_rxs) begin
                        w_push       = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_ferr_next  = 1'b1;
                        w_state_next = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // Wait for the line to return high so a held-low line cannot retrigger.
                if (r_rxs) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_pop  = rx_valid & rx_ready;
    assign w_drop = w_push & w_full & ~w_pop;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_sync1     <= 1'b1;
            r_rxs       <= 1'b1;
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_sync1     <= rxd;
            r_rxs       <= r_sync1;
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_bit_idx   <= w_bit_next;
            r_shift     <= w_shift_next;
            r_frame_err <= w_ferr_next;
            r_overrun   <= w_drop | (r_overrun & ~clr_overrun);
            r_busy      <= (w_state_next != ST_IDLE);
        end
    end

    mcu51_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .i_clk   (CLK),
        .i_reset (reset),
        .i_push  (w_push),
        .i_wdata (r_shift),
        .i_pop   (w_pop),
        .o_rdata (rx_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign rx_valid  = ~w_empty;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mcu51_serial_rx.sv
// Directed and randomized frames against a queue-based model of the receive path.
module tb_mcu51_serial_rx;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;
    localparam int LAT   = 2 + CPB / 2 + 9 * CPB + 1;

    logic       CLK = 1'b0;
    logic       reset;
    logic       rxd;
    logic       clr_overrun;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    mcu51_serial_rx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .rxd         (rxd),
        .clr_overrun (clr_overrun),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 CLK = ~CLK;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] mq[$];
    int         pend_cyc[$];
    logic [7:0] pend_dat[$];
    logic       m_ovr = 1'b0;
    int         ferr_cyc = -1;
    logic [7:0] got[$];
    bit         rand_ready = 1'b0;
    bit         ready_on_arrival = 1'b0;
    int         ferr_seen = 0;
    bit         saw_busy = 1'b0;
    int         t_fall = -1;
    int         lat = -1;
    logic       prev_v = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    // One clock: update the model for this edge, then compare the DUT just after it.
    task automatic step();
        bit         pop_now;
        bit         clr_now;
        bit         rst_now;
        bit         drop;
        logic [7:0] d;
        if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
        if (ready_on_arrival) rx_ready = (pend_cyc.size() > 0 && pend_cyc[0] == cyc + 1);
        pop_now = (mq.size() > 0) && (rx_ready === 1'b1);
        clr_now = clr_overrun;
        rst_now = reset;
        if (pop_now && !rst_now) got.push_back(rx_data);
        @(posedge CLK);
        cyc++;
        if (rst_now) begin
            mq.delete();
            pend_cyc.delete();
            pend_dat.delete();
            m_ovr    = 1'b0;
            ferr_cyc = -1;
        end else begin
            drop = 1'b0;
            if (pop_now) void'(mq.pop_front());
            if (pend_cyc.size() > 0 && pend_cyc[0] == cyc) begin
                void'(pend_cyc.pop_front());
                d = pend_dat.pop_front();
                if (mq.size() < DEPTH) mq.push_back(d);
                else drop = 1'b1;
            end
            m_ovr = drop | (m_ovr & !clr_now);
        end
        #1;
        chk("rx_valid", 32'(rx_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) chk("rx_data", 32'(rx_data), 32'(mq[0]));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("frame_err", 32'(frame_err), 32'(cyc == ferr_cyc));
        if (frame_err === 1'b1) ferr_seen++;
        if (busy === 1'b1) saw_busy = 1'b1;
        if (rx_valid === 1'b1 && prev_v !== 1'b1 && t_fall >= 0 && lat < 0) lat = cyc - t_fall;
        prev_v = rx_valid;
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) step();
    endtask

    // Drive start, ndata data bits LSB first, and the stop bit when the frame is complete.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input int ndata);
        int c0;
        c0 = cyc;
        if (ndata == 8) begin
            if (stop_b) begin
                pend_cyc.push_back(c0 + LAT);
                pend_dat.push_back(d);
            end else begin
                ferr_cyc = c0 + LAT;
            end
        end
        rxd = 1'b0;
        repeat (CPB) step();
        for (int i = 0; i < ndata; i++) begin
            rxd = d[i];
            repeat (CPB) step();
        end
        if (ndata == 8) begin
            rxd = stop_b;
            repeat (CPB) step();
        end
    endtask

    initial begin
        logic [7:0] b;
        reset       = 1'b1;
        rxd         = 1'b1;
        clr_overrun = 1'b0;
        rx_ready    = 1'b0;
        repeat (3) step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        reset = 1'b0;
        idle(4);

        // Single good frame, consumer always ready; latency from the falling edge.
        rx_ready = 1'b1;
        got.delete();
        t_fall = cyc;
        lat    = -1;
        send_frame(8'hA5, 1'b1, 8);
        idle(4);
        chk("t1_latency", 32'(lat), 32'(LAT));
        chk("t1_count", 32'(got.size()), 32'd1);
        if (got.size() > 0) chk("t1_byte", 32'(got[0]), 32'hA5);
        t_fall = -1;

        // Short low glitch.
        saw_busy = 1'b0;
        rxd = 1'b0;
        repeat (3) step();
        rxd = 1'b1;
        repeat (12) step();
        chk("t2_saw_busy", 32'(saw_busy), 32'd1);
        chk("t2_busy_end", 32'(busy), 32'd0);

        // Bad stop bit, held-low line, then a good frame.
        got.delete();
        ferr_seen = 0;
        send_frame(8'h3C, 1'b0, 8);
        rxd = 1'b0;
        repeat (40) step();
        chk("t3_busy_hold", 32'(busy), 32'd1);
        idle(2 * CPB);
        send_frame(8'h55, 1'b1, 8);
        idle(4);
        chk("t3_ferr_pulses", 32'(ferr_seen), 32'd1);
        chk("t3_count", 32'(got.size()), 32'd1);
        if (got.size() > 0) chk("t3_byte", 32'(got[0]), 32'h55);

        // Overflow with consumer stalled, then drain and clear.
        rx_ready = 1'b0;
        got.delete();
        for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1, 8);
        idle(4);
        chk("t4_overrun", 32'(overrun), 32'd1);
        rx_ready = 1'b1;
        repeat (8) step();
        chk("t4_count", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk("t4_order", 32'(got[i]), 32'(i + 1));
        chk("t4_valid_low", 32'(rx_valid), 32'd0);
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        step();
        chk("t4_clr", 32'(overrun), 32'd0);

        // Full FIFO with a pop on the same edge as the fifth push.
        rx_ready = 1'b0;
        got.delete();
        for (int k = 1; k <= 4; k++) send_frame(8'(k), 1'b1, 8);
        ready_on_arrival = 1'b1;
        send_frame(8'h05, 1'b1, 8);
        ready_on_arrival = 1'b0;
        rx_ready = 1'b0;
        idle(2);
        chk("t5_no_overrun", 32'(overrun), 32'd0);
        chk("t5_one_pop", 32'(got.size()), 32'd1);
        rx_ready = 1'b1;
        repeat (8) step();
        chk("t5_count", 32'(got.size()), 32'd5);
        for (int i = 0; i < 5 && i < got.size(); i++) chk("t5_order", 32'(got[i]), 32'(i + 1));

        // Reset in the middle of a frame while a byte is buffered.
        rx_ready = 1'b0;
        got.delete();
        b = 8'($urandom_range(1, 255));
        send_frame(b, 1'b1, 8);
        idle(2);
        chk("t6_pre_valid", 32'(rx_valid), 32'd1);
        send_frame(8'($urandom), 1'b1, 4);
        reset = 1'b1;
        rxd   = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_rx_valid", 32'(rx_valid), 32'd0);
        chk("t6_rx_data", 32'(rx_data), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_frame_err", 32'(frame_err), 32'd0);
        idle(2 * CPB);
        rx_ready = 1'b1;
        send_frame(8'h80, 1'b1, 8);
        idle(4);
        chk("t6_count", 32'(got.size()), 32'd1);
        if (got.size() > 0) chk("t6_byte", 32'(got[0]), 32'h80);

        // Random bytes, random gaps, random consumer back-pressure.
        rand_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            send_frame(8'($urandom), 1'b1, 8);
            idle($urandom_range(0, 5));
        end
        rand_ready = 1'b0;
        rx_ready   = 1'b1;
        idle(12);
        chk("t7_drained", 32'(rx_valid), 32'd0);
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        step();
        chk("t7_clr", 32'(overrun), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
